// File: rtl/uart_rx_stream.sv
// uart_rx_stream: 2-flop synchronised 8N1 receiver feeding a byte FIFO; UART_RX_PARITY_EN adds an even-parity bit.
// Latency: 2 clk synchroniser, byte on m_data/m_valid the clk after the stop-bit sample (FIFO empty).
// Backpressure: FIFO holds FIFO_DEPTH bytes; a byte completing while full (and not popped) is dropped with an overrun pulse.
module uart_rx_stream #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = AW + 1;
    localparam logic [OW-1:0] OCC_FULL = OW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    logic             sync1, rxs, rxs_q;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_idx, bit_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic             frame_ok;
    logic             push_vld;

    // FIFO state
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [OW-1:0] occ;
    logic          push_rdy, push, pop;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection; idle level is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
            rxs_q <= 1'b1;
        end else begin
            sync1 <= rx_i;
            rxs   <= sync1;
            rxs_q <= rxs;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_ok, par_nxt;
    assign frame_ok = par_ok;
`else
    assign frame_ok = 1'b1;
`endif

    // Receive FSM state, bit-time counter, data bit index and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
`ifdef UART_RX_PARITY_EN
            par_ok  <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_nxt;
            shreg   <= shreg_nxt;
`ifdef UART_RX_PARITY_EN
            par_ok  <= par_nxt;
`endif
        end
    end

    // Next-state logic; the bit counter restarts from zero on every state change.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        bit_nxt   = bit_idx;
        shreg_nxt = shreg;
        push_vld  = 1'b0;
        frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_nxt   = par_ok;
`endif
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (rxs_q && !rxs) state_nxt = S_START;
            end
            S_START: begin
                if (cnt == HALF_END) begin
                    cnt_nxt   = '0;
                    bit_nxt   = '0;
                    state_nxt = rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == BIT_END) begin
                    cnt_nxt   = '0;
                    shreg_nxt = {rxs, shreg[7:1]};
                    bit_nxt   = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = S_PARITY;
`else
                        state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt == BIT_END) begin
                    cnt_nxt   = '0;
                    par_nxt   = ~(^shreg ^ rxs);
                    state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt == BIT_END) begin
                    cnt_nxt = '0;
                    if (!frame_ok) begin
                        // Bad parity: drop the byte, but the line is not stuck so no BREAK wait.
                        frame_err = 1'b1;
                        state_nxt = S_IDLE;
                    end else if (rxs) begin
                        push_vld  = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                cnt_nxt = '0;
                if (rxs) state_nxt = S_IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy = (state != S_IDLE);

    // Byte FIFO: a full FIFO still accepts a push when the head is popped in the same cycle.
    assign m_valid  = (occ != '0);
    assign m_data   = mem[rd_ptr];
    assign pop      = m_valid & m_ready;
    assign push_rdy = (occ != OCC_FULL) | pop;
    assign push     = push_vld & push_rdy;
    assign overrun  = push_vld & ~push_rdy;

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      occ <= occ + 1'b1;
            else if (pop && !push) occ <= occ - 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_rx_stream.sv
// tb_uart_rx_stream: directed and randomised serial frames checked against a queue-based byte model.
// Latency: stop-bit sample to m_valid checked cycle-exactly on one frame; others checked by content.
// Backpressure: m_ready held low to fill the FIFO, then drained and compared in order.
module tb_uart_rx_stream;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_i;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    uart_rx_stream #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_i      (rx_i),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Collect delivered bytes and pulse counts away from the active edge.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) got_q.push_back(m_data);
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_q(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic drive_level(input logic v, input int cycles);
        rx_i = v;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Start bit, 8 data bits LSB first, and the parity bit when that build option is on.
    task automatic send_head(input logic [7:0] d, input logic bad_par);
        drive_level(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_level(d[i], CPB);
`ifdef UART_RX_PARITY_EN
        drive_level((^d) ^ bad_par, CPB);
`else
        if (bad_par) drive_level(1'b1, 0);
`endif
    endtask

    task automatic send_frame(input logic [7:0] d);
        send_head(d, 1'b0);
        drive_level(1'b1, CPB + 4);
    endtask

    task automatic drain();
        m_ready = 1'b1;
        repeat (DEPTH + 2) @(posedge clk);
        #1;
        m_ready = 1'b0;
    endtask

    initial begin
        int fe0, ov0, k, gap;
        logic [7:0] d;

        rst_n = 1'b0;
        rx_i = 1'b1;
        m_ready = 1'b0;

        // Reset values
        @(negedge clk);
        check("rst_valid", m_valid, 1'b0);
        check("rst_data", m_data, 8'h00);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        check("rst_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_level(1'b1, 5);

        // 0xA5 with cycle-exact delivery after the stop-bit sample
        m_ready = 1'b1;
        fe0 = fe_cnt; ov0 = ov_cnt;
        send_head(8'hA5, 1'b0);
        rx_i = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        @(negedge clk);
        check("a5_valid_early", m_valid, 1'b0);
        @(negedge clk);
        check("a5_valid", m_valid, 1'b1);
        check("a5_data", m_data, 8'hA5);
        @(negedge clk);
        check("a5_valid_one_cycle", m_valid, 1'b0);
        @(posedge clk); #1;
        drive_level(1'b1, 8);
        exp_q.push_back(8'hA5);
        check_q("a5");
        check("a5_ferr", fe_cnt - fe0, 0);
        check("a5_ovr", ov_cnt - ov0, 0);

        // Overrun: five bytes into a four-entry FIFO with no consumer
        m_ready = 1'b0;
        fe0 = fe_cnt; ov0 = ov_cnt;
        for (int i = 1; i <= 4; i++) begin
            send_frame(8'(i));
            exp_q.push_back(8'(i));
        end
        send_frame(8'h55);
        check("ovr_pulses", ov_cnt - ov0, 1);
        check("ovr_ferr", fe_cnt - fe0, 0);
        drain();
        check_q("ovr");
        @(negedge clk);
        check("ovr_empty", m_valid, 1'b0);

        // Full FIFO with a pop exactly in the fifth byte's push cycle
        ov0 = ov_cnt;
        for (int i = 1; i <= 4; i++) begin
            send_frame(8'(i));
            exp_q.push_back(8'(i));
        end
        send_head(8'h55, 1'b0);
        rx_i = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        m_ready = 1'b1;
        @(negedge clk);
        check("pp_full_valid", m_valid, 1'b1);
        check("pp_no_ovr", overrun, 1'b0);
        @(posedge clk); #1;
        m_ready = 1'b0;
        drive_level(1'b1, 8);
        exp_q.push_back(8'h55);
        drain();
        check_q("pp");
        check("pp_ovr_total", ov_cnt - ov0, 0);

        // Short low glitch: false start, no byte, no error
        m_ready = 1'b1;
        fe0 = fe_cnt;
        drive_level(1'b0, 4);
        rx_i = 1'b1;
        @(negedge clk);
        check("glitch_busy", busy, 1'b1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("glitch_idle", busy, 1'b0);
        drive_level(1'b1, 20);
        check("glitch_ferr", fe_cnt - fe0, 0);
        check_q("glitch");

        // Stop bit held low: one frame_err, wait for line high, then recover
        fe0 = fe_cnt;
        send_head(8'h3C, 1'b0);
        drive_level(1'b0, 40);
        @(negedge clk);
        check("brk_busy", busy, 1'b1);
        check("brk_ferr", fe_cnt - fe0, 1);
        rx_i = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("brk_idle", busy, 1'b0);
        drive_level(1'b1, 10);
        send_frame(8'h7E);
        exp_q.push_back(8'h7E);
        check_q("brk");
        check("brk_ferr_total", fe_cnt - fe0, 1);

        // Reset mid-DATA aborts the frame and empties the FIFO
        m_ready = 1'b0;
        send_frame(8'h5A);
        drive_level(1'b0, CPB);
        drive_level(1'b1, 3 * CPB);
        @(negedge clk);
        check("rst_mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", m_valid, 1'b0);
        check("rst_mid_data", m_data, 8'h00);
        check("rst_mid_busy0", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        got_q.delete();
        drive_level(1'b1, 20);
        m_ready = 1'b1;
        send_frame(8'h12);
        exp_q.push_back(8'h12);
        check_q("rst_mid");
        @(negedge clk);
        check("rst_mid_empty", m_valid, 1'b0);

`ifdef UART_RX_PARITY_EN
        // Parity: odd parity rejected without BREAK, even parity accepted
        fe0 = fe_cnt;
        send_head(8'h12, 1'b1);
        drive_level(1'b1, CPB + 4);
        check("par_bad_ferr", fe_cnt - fe0, 1);
        @(negedge clk);
        check("par_bad_idle", busy, 1'b0);
        check_q("par_bad");
        send_frame(8'h12);
        exp_q.push_back(8'h12);
        check_q("par_good");
        check("par_good_ferr", fe_cnt - fe0, 1);
`endif

        // Random byte stream with an always-ready consumer
        fe0 = fe_cnt; ov0 = ov_cnt;
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            gap = int'($urandom_range(0, 20));
            drive_level(1'b1, gap);
            send_frame(d);
            exp_q.push_back(d);
        end
        check_q("rand_stream");
        check("rand_stream_ferr", fe_cnt - fe0, 0);
        check("rand_stream_ovr", ov_cnt - ov0, 0);

        // Random bursts against a stalled consumer
        for (int b = 0; b < 3; b++) begin
            m_ready = 1'b0;
            ov0 = ov_cnt;
            k = int'($urandom_range(2, 7));
            for (int i = 0; i < k; i++) begin
                d = 8'($urandom);
                send_frame(d);
                if (i < DEPTH) exp_q.push_back(d);
            end
            check($sformatf("burst%0d_ovr", b), ov_cnt - ov0, (k > DEPTH) ? k - DEPTH : 0);
            drain();
            check_q($sformatf("burst%0d", b));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
